// File: rtl/spi_sclk_engine.sv
// SPI master frame timing engine: chip-select setup/hold, SCLK generation and
// per-bit shift/sample strobes for one frame of a programmable bit count.
module spi_sclk_engine #(
   parameter int DIV_WIDTH = 8,
   parameter int CNT_WIDTH = 6,
   parameter int DLY_WIDTH = 4
) (
   input  logic                 i_sys_clk,
   input  logic                 i_rst,
   input  logic [DIV_WIDTH-1:0] i_divider,
   input  logic                 i_cpol,
   input  logic                 i_cpha,
   input  logic [CNT_WIDTH-1:0] i_num_bits,
   input  logic [DLY_WIDTH-1:0] i_cs_setup,
   input  logic [DLY_WIDTH-1:0] i_cs_hold,
   input  logic                 i_start,
   input  logic                 i_abort,
   output logic                 o_busy,
   output logic                 o_done,
   output logic                 o_cs_n,
   output logic                 o_sclk,
   output logic                 o_shift,
   output logic                 o_sample
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_SETUP = 2'd1,
      S_RUN   = 2'd2,
      S_HOLD  = 2'd3
   } state_t;

   state_t               r_state;
   logic [DIV_WIDTH-1:0] r_div;
   logic [DIV_WIDTH-1:0] r_cnt;
   logic [CNT_WIDTH-1:0] r_nbits;
   logic [DLY_WIDTH-1:0] r_setup;
   logic [DLY_WIDTH-1:0] r_hold;
   logic [DLY_WIDTH-1:0] r_dly;
   logic [CNT_WIDTH:0]   r_edge;
   logic                 r_cpol;
   logic                 r_cpha;
   logic                 r_busy;
   logic                 r_done;
   logic                 r_cs_n;
   logic                 r_sclk;
   logic                 r_shift;
   logic                 r_sample;

   logic                 w_tick;
   logic [CNT_WIDTH:0]   w_next_edge;
   logic                 w_last_edge;
   logic                 w_leading;

   // w_tick marks the final sys_clk cycle of the current SCLK half-period.
   assign w_tick      = (r_cnt == r_div);
   assign w_next_edge = r_edge + (CNT_WIDTH+1)'(1);
   assign w_last_edge = (w_next_edge == {r_nbits, 1'b0});
   assign w_leading   = w_next_edge[0];

   // Frame sequencer: state, counters, latched configuration and all outputs.
   always_ff @(posedge i_sys_clk) begin
      if (i_rst) begin
         r_state  <= S_IDLE;
         r_div    <= '0;
         r_cnt    <= '0;
         r_nbits  <= '0;
         r_setup  <= '0;
         r_hold   <= '0;
         r_dly    <= '0;
         r_edge   <= '0;
         r_cpol   <= 1'b0;
         r_cpha   <= 1'b0;
         r_busy   <= 1'b0;
         r_done   <= 1'b0;
         r_cs_n   <= 1'b1;
         r_sclk   <= i_cpol;
         r_shift  <= 1'b0;
         r_sample <= 1'b0;
      end else begin
         r_done   <= 1'b0;
         r_shift  <= 1'b0;
         r_sample <= 1'b0;
         if ((r_state != S_IDLE) && i_abort) begin
            r_state <= S_IDLE;
            r_cs_n  <= 1'b1;
            r_sclk  <= r_cpol;
            r_busy  <= 1'b0;
            r_cnt   <= '0;
            r_dly   <= '0;
            r_edge  <= '0;
         end else begin
            r_cnt <= ((r_state == S_IDLE) || w_tick) ? '0 : r_cnt + DIV_WIDTH'(1);
            case (r_state)
               S_IDLE: begin
                  r_sclk <= i_cpol;
                  if (i_start && !i_abort && (i_num_bits != '0)) begin
                     r_div   <= i_divider;
                     r_cpol  <= i_cpol;
                     r_cpha  <= i_cpha;
                     r_nbits <= i_num_bits;
                     r_setup <= i_cs_setup;
                     r_hold  <= i_cs_hold;
                     r_dly   <= '0;
                     r_edge  <= '0;
                     r_state <= S_SETUP;
                     r_cs_n  <= 1'b0;
                     r_busy  <= 1'b1;
                     r_shift <= ~i_cpha;
                  end
               end
               S_SETUP: begin
                  // Leaving SETUP coincides with SCLK edge 1 (always a leading edge).
                  if (w_tick) begin
                     if (r_dly == r_setup) begin
                        r_state  <= S_RUN;
                        r_sclk   <= ~r_sclk;
                        r_edge   <= (CNT_WIDTH+1)'(1);
                        r_sample <= ~r_cpha;
                        r_shift  <= r_cpha;
                     end else begin
                        r_dly <= r_dly + DLY_WIDTH'(1);
                     end
                  end
               end
               S_RUN: begin
                  if (w_tick) begin
                     r_sclk <= ~r_sclk;
                     r_edge <= w_next_edge;
                     if (w_leading) begin
                        r_sample <= ~r_cpha;
                        r_shift  <= r_cpha;
                     end else begin
                        r_sample <= r_cpha;
                        r_shift  <= ~r_cpha & ~w_last_edge;
                     end
                     if (w_last_edge) begin
                        r_state <= S_HOLD;
                        r_dly   <= '0;
                     end
                  end
               end
               S_HOLD: begin
                  if (w_tick) begin
                     if (r_dly == r_hold) begin
                        r_state <= S_IDLE;
                        r_cs_n  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                     end else begin
                        r_dly <= r_dly + DLY_WIDTH'(1);
                     end
                  end
               end
               default: begin
                  r_state <= S_IDLE;
                  r_cs_n  <= 1'b1;
                  r_busy  <= 1'b0;
                  r_sclk  <= r_cpol;
               end
            endcase
         end
      end
   end

   assign o_busy   = r_busy;
   assign o_done   = r_done;
   assign o_cs_n   = r_cs_n;
   assign o_sclk   = r_sclk;
   assign o_shift  = r_shift;
   assign o_sample = r_sample;

endmodule

// File: tb/tb_spi_sclk_engine.sv
// Bench for spi_sclk_engine: directed frame table, corner-case sequences and
// randomized frames compared cycle by cycle against a timing-formula model.
module tb_spi_sclk_engine;
   localparam int DW = 8;
   localparam int CW = 6;
   localparam int LW = 4;

   logic          clk = 1'b0;
   logic          rst, cpol, cpha, start, abort;
   logic [DW-1:0] divider;
   logic [CW-1:0] num_bits;
   logic [LW-1:0] cs_setup, cs_hold;
   logic          busy, done, cs_n, sclk, shift, sample;
   int            checks = 0;
   int            errors = 0;

   typedef struct {
      bit cpol;
      bit cpha;
      int div;
      int n;
      int setup;
      int hold;
      int first_edge;
      int done_cyc;
   } vec_t;

   spi_sclk_engine #(.DIV_WIDTH(DW), .CNT_WIDTH(CW), .DLY_WIDTH(LW)) dut (
      .i_sys_clk (clk),
      .i_rst     (rst),
      .i_divider (divider),
      .i_cpol    (cpol),
      .i_cpha    (cpha),
      .i_num_bits(num_bits),
      .i_cs_setup(cs_setup),
      .i_cs_hold (cs_hold),
      .i_start   (start),
      .i_abort   (abort),
      .o_busy    (busy),
      .o_done    (done),
      .o_cs_n    (cs_n),
      .o_sclk    (sclk),
      .o_shift   (shift),
      .o_sample  (sample)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(string name, int act, int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   function automatic logic [5:0] outs();
      return {busy, done, cs_n, sclk, shift, sample};
   endfunction

   task automatic apply(bit pol, bit pha, int dv, int n, int su, int ho);
      cpol     = pol;
      cpha     = pha;
      divider  = DW'(dv);
      num_bits = CW'(n);
      cs_setup = LW'(su);
      cs_hold  = LW'(ho);
   endtask

   // Expected {busy,done,cs_n,sclk,shift,sample} in cycle c after the start edge.
   function automatic logic [5:0] model(bit pol, bit pha, int dv, int n, int su, int ho, int c);
      int d, s, h, tend, nedge, k;
      bit b_shift, b_sample;
      d = dv + 1;
      s = (su + 1) * d;
      h = (ho + 1) * d;
      tend = 1 + s + (2 * n - 1) * d + h;
      nedge = 0;
      k = 0;
      b_shift = 1'b0;
      b_sample = 1'b0;
      if (c >= tend) return {1'b0, (c == tend), 1'b1, pol, 1'b0, 1'b0};
      if (c >= 1 + s) begin
         nedge = (c - 1 - s) / d + 1;
         if (nedge > 2 * n) nedge = 2 * n;
         else if ((c - 1 - s) % d == 0) k = nedge;
      end
      if (c == 1 && !pha) b_shift = 1'b1;
      if (k != 0) begin
         if (k % 2 == 1) begin
            if (pha) b_shift = 1'b1;
            else     b_sample = 1'b1;
         end else begin
            if (pha)         b_sample = 1'b1;
            else if (k < 2*n) b_shift = 1'b1;
         end
      end
      return {1'b1, 1'b0, 1'b0, pol ^ (nedge % 2 == 1), b_shift, b_sample};
   endfunction

   task automatic run_vec(int i, vec_t v);
      int first, donec, sh, sa, both;
      first = 0; donec = 0; sh = 0; sa = 0; both = 0;
      apply(v.cpol, v.cpha, v.div, v.n, v.setup, v.hold);
      start = 1'b1;
      for (int c = 1; c <= 400; c++) begin
         step();
         if (c == 1) begin
            start = 1'b0;
            check($sformatf("vec%0d_cs_fall", i), cs_n, 0);
         end
         if (first == 0 && sclk != v.cpol) first = c;
         sh += int'(shift);
         sa += int'(sample);
         both += int'(shift & sample);
         if (done) begin
            donec = c;
            break;
         end
      end
      check($sformatf("vec%0d_first_edge", i), first, v.first_edge);
      check($sformatf("vec%0d_done_cycle", i), donec, v.done_cyc);
      check($sformatf("vec%0d_shifts", i), sh, v.n);
      check($sformatf("vec%0d_samples", i), sa, v.n);
      check($sformatf("vec%0d_overlap", i), both, 0);
      step();
      check($sformatf("vec%0d_idle_after", i), {cs_n, sclk}, {1'b1, v.cpol});
   endtask

   task automatic run_random(int idx);
      bit pol, pha;
      int dv, n, su, ho, tend, sh, sa;
      pol = 1'($urandom_range(0, 1));
      pha = 1'($urandom_range(0, 1));
      dv  = $urandom_range(0, 5);
      n   = $urandom_range(1, 10);
      su  = $urandom_range(0, 3);
      ho  = $urandom_range(0, 3);
      tend = 1 + (su + 1) * (dv + 1) + (2 * n - 1) * (dv + 1) + (ho + 1) * (dv + 1);
      sh = 0; sa = 0;
      apply(pol, pha, dv, n, su, ho);
      start = 1'b1;
      for (int c = 1; c <= tend + 2; c++) begin
         step();
         check($sformatf("rand%0d_c%0d", idx, c), outs(), model(pol, pha, dv, n, su, ho, c));
         sh += int'(shift);
         sa += int'(sample);
         // Mid-frame input churn, including stray starts, must not disturb the frame.
         if (c < tend - 1) begin
            apply(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom_range(0, 255),
                  $urandom_range(0, 63), $urandom_range(0, 15), $urandom_range(0, 15));
            start = ($urandom_range(0, 7) == 0);
         end else begin
            apply(pol, pha, dv, n, su, ho);
            start = 1'b0;
         end
      end
      check($sformatf("rand%0d_shifts", idx), sh, n);
      check($sformatf("rand%0d_samples", idx), sa, n);
   endtask

   initial begin
      vec_t vt[7];
      int   seen, d1, d2;
      vt[0] = '{1'b0, 1'b0, 1, 8, 0, 0, 3, 35};
      vt[1] = '{1'b0, 1'b0, 0, 1, 0, 0, 2, 4};
      vt[2] = '{1'b0, 1'b1, 0, 1, 0, 0, 2, 4};
      vt[3] = '{1'b1, 1'b0, 0, 1, 0, 0, 2, 4};
      vt[4] = '{1'b1, 1'b1, 0, 1, 0, 0, 2, 4};
      vt[5] = '{1'b1, 1'b1, 4, 4, 3, 2, 21, 71};
      vt[6] = '{1'b1, 1'b0, 2, 5, 1, 0, 7, 37};

      rst = 1'b1; start = 1'b0; abort = 1'b0;
      apply(1'b1, 1'b0, 0, 0, 0, 0);
      step();
      step();
      check("reset_outs", outs(), 6'b001100);
      rst = 1'b0;
      cpol = 1'b0;
      step();
      check("idle_sclk_follows_cpol", {busy, cs_n, sclk}, 3'b010);

      for (int i = 0; i < 7; i++) run_vec(i, vt[i]);

      // Abort after SCLK edge 5 (cycle 11 with D=2, S=2).
      apply(1'b1, 1'b0, 1, 8, 0, 0);
      start = 1'b1;
      for (int c = 1; c <= 11; c++) begin
         step();
         if (c == 1) start = 1'b0;
      end
      check("abort_pre_sclk", sclk, 0);
      abort = 1'b1;
      step();
      abort = 1'b0;
      check("abort_outs", outs(), 6'b001100);
      seen = 0;
      for (int c = 0; c < 40; c++) begin
         step();
         seen += int'(done | busy);
      end
      check("abort_no_done", seen, 0);

      start = 1'b1; abort = 1'b1;
      step();
      start = 1'b0; abort = 1'b0;
      check("abort_beats_start", busy, 0);

      num_bits = '0; start = 1'b1;
      step();
      start = 1'b0;
      check("nbits0_ignored", {busy, cs_n}, 2'b01);

      num_bits = CW'(8); start = 1'b1;
      step();
      start = 1'b0;
      check("restart_after_abort", {busy, cs_n, shift}, 3'b101);

      // Reset in RUN: edges at cycles 3,5,7 so sclk is low in cycle 8.
      for (int c = 2; c <= 8; c++) step();
      check("rst_pre_sclk", sclk, 0);
      rst = 1'b1;
      step();
      rst = 1'b0;
      check("rst_mid_run_outs", outs(), 6'b001100);
      step();

      // Back-to-back: start during the done cycle.
      apply(1'b0, 1'b1, 0, 1, 0, 0);
      start = 1'b1;
      d1 = 0;
      for (int c = 1; c <= 10; c++) begin
         step();
         if (c == 1) start = 1'b0;
         if (done) begin
            d1 = c;
            start = 1'b1;
            break;
         end
      end
      check("b2b_first_done", d1, 4);
      step();
      start = 1'b0;
      check("b2b_cs_refall", {cs_n, busy, done}, 3'b010);
      d2 = 0;
      for (int c = 2; c <= 10; c++) begin
         step();
         if (done) begin
            d2 = c;
            break;
         end
      end
      check("b2b_second_done", d2, 4);
      step();

      for (int r = 0; r < 20; r++) run_random(r);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
